// File: rtl/imu_window_avg.sv
// Sliding-window moving average of IMU samples with an output FIFO.
// Define IMU_AVG_ROUND_EN for round-half-up averages instead of truncation.
module imu_window_avg #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN        = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           win_full,
  output logic [$clog2(OUT_DEPTH):0]     fifo_level,
  output logic                           overflow
);

  localparam int LW  = $clog2(WIN);
  localparam int SW  = DATA_WIDTH + LW;
  localparam int AW  = $clog2(OUT_DEPTH);
  localparam int LVW = AW + 1;
  localparam logic [LW:0]    C_LAST = (LW+1)'(WIN - 1);
  localparam logic [LVW-1:0] C_FULL = LVW'(OUT_DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf [WIN];
  logic [SW-1:0]         r_sum;
  logic [LW-1:0]         r_ptr;
  logic [LW:0]           r_cnt;
  logic                  r_win_full;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [LVW-1:0]        r_level;

  logic [DATA_WIDTH-1:0] w_oldest;
  logic [SW-1:0]         w_sum_next;
  logic [DATA_WIDTH-1:0] w_avg;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;

  // Slots not yet written in FILL hold zero, so one update serves both states
  assign w_oldest   = r_buf[r_ptr];
  assign w_sum_next = r_sum + SW'(in_data) - SW'(w_oldest);

`ifdef IMU_AVG_ROUND_EN
  assign w_avg = DATA_WIDTH'((w_sum_next + SW'(WIN / 2)) >> LW);
`else
  assign w_avg = DATA_WIDTH'(w_sum_next >> LW);
`endif

  assign w_push = in_valid && !flush
               && ((r_state == RUN) || (r_cnt == C_LAST));
  assign w_full = (r_level == C_FULL);
  assign w_pop  = out_valid && out_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  assign out_valid  = (r_level != '0);
  assign out_data   = r_mem[r_rp];
  assign fifo_level = r_level;
  assign win_full   = r_win_full;
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_sum      <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_win_full <= 1'b0;
      r_overflow <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (flush) begin
        r_state    <= FILL;
        r_sum      <= '0;
        r_ptr      <= '0;
        r_cnt      <= '0;
        r_win_full <= 1'b0;
        r_overflow <= 1'b0;
        for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      end else if (in_valid) begin
        r_buf[r_ptr] <= in_data;
        r_ptr        <= r_ptr + 1'b1;
        r_sum        <= w_sum_next;
        if (r_state == FILL) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state    <= RUN;
            r_win_full <= 1'b1;
          end
        end
        if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end

      if (w_wr) begin
        r_mem[r_wp] <= w_avg;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_wr && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_wr && w_pop)
        r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: tb/tb_imu_window_avg.sv
// Scoreboard bench for imu_window_avg: directed samples, queued averages.
// A negedge monitor pops the queue on every accepted output.
module tb_imu_window_avg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        win_full;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  imu_window_avg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .win_full(win_full),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected none", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    chk("drain_done", 32'(out_valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_win_full", 32'(win_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    step();

    // 1: fill then two averages held
    out_ready = 1'b0;
    send(16'd100); chk("t1_nv0", 32'(out_valid), 0);
    send(16'd102); chk("t1_nv1", 32'(out_valid), 0);
    send(16'd104); chk("t1_nv2", 32'(out_valid), 0);
    chk("t1_wf_pre", 32'(win_full), 0);
    exp_q.push_back(16'd103);
    send(16'd106);
    chk("t1_wf", 32'(win_full), 1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_head", 32'(out_data), 103);
    chk("t1_lvl1", 32'(fifo_level), 1);
    exp_q.push_back(16'd105);
    send(16'd108);
    chk("t1_lvl2", 32'(fifo_level), 2);
    chk("t1_hold", 32'(out_data), 103);
    drain();

    // 2: streaming with consumer always ready
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i >= 3) exp_q.push_back(16'(103 + 2 * (i - 3)));
      send(16'(100 + 2 * i));
      if (i >= 3) chk("t2_valid", 32'(out_valid), 1);
    end
    chk("t2_ovf", 32'(overflow), 0);
    drain();

    // 3: stalled consumer overflows
    out_ready = 1'b0;
    do_flush();
    for (int i = 0; i < 10; i++) send(16'(100 + 2 * i));
    for (int k = 0; k < 4; k++) exp_q.push_back(16'(103 + 2 * k));
    chk("t3_lvl", 32'(fifo_level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_head", 32'(out_data), 103);
    drain();

    // 4: push into a full FIFO with a same-cycle pop
    out_ready = 1'b0;
    do_flush();
    chk("t4_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) send(16'(100 + 2 * i));
    for (int k = 0; k < 5; k++) exp_q.push_back(16'(103 + 2 * k));
    chk("t4_full", 32'(fifo_level), 4);
    out_ready = 1'b1;
    send(16'd114);
    out_ready = 1'b0;
    chk("t4_lvl", 32'(fifo_level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(out_data), 105);
    drain();

    // 5: flush beats a simultaneous sample
    out_ready = 1'b1;
    do_flush();
    for (int i = 0; i < 6; i++) begin
      if (i >= 3) exp_q.push_back(16'(103 + 2 * (i - 3)));
      send(16'(100 + 2 * i));
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd999;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_wf", 32'(win_full), 0);
    send(16'd10); chk("t5_nv0", 32'(out_valid), 0);
    send(16'd20); chk("t5_nv1", 32'(out_valid), 0);
    send(16'd30); chk("t5_nv2", 32'(out_valid), 0);
    exp_q.push_back(16'd25);
    send(16'd40);
    chk("t5_valid", 32'(out_valid), 1);
    drain();

    // 6: rounding mode
    out_ready = 1'b0;
    do_flush();
    send(16'd1); send(16'd2); send(16'd2); send(16'd2);
`ifdef IMU_AVG_ROUND_EN
    chk("t6_avg", 32'(out_data), 2);
    exp_q.push_back(16'd2);
`else
    chk("t6_avg", 32'(out_data), 1);
    exp_q.push_back(16'd1);
`endif
    drain();

    // 7: async reset mid-stream
    out_ready = 1'b0;
    do_flush();
    for (int i = 0; i < 6; i++) send(16'(100 + 2 * i));
    chk("t7_lvl3", 32'(fifo_level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_data", 32'(out_data), 0);
    chk("t7_lvl", 32'(fifo_level), 0);
    chk("t7_wf", 32'(win_full), 0);
    chk("t7_ovf", 32'(overflow), 0);
    step();
    rst_n = 1'b1;
    step();
    send(16'd50); chk("t7_nv0", 32'(out_valid), 0);
    send(16'd60); chk("t7_nv1", 32'(out_valid), 0);
    send(16'd70); chk("t7_nv2", 32'(out_valid), 0);
    exp_q.push_back(16'd65);
    send(16'd80);
    chk("t7_lvl1", 32'(fifo_level), 1);
    chk("t7_avg", 32'(out_data), 65);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
